// File: rtl/spi_flash_reader.sv
// SPI-NOR READ (0x03) sequencer and mode-0 SPI master.
// Streams len bytes from a 24-bit flash address out over a valid/ready byte port.
module spi_flash_reader #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned LEN_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [23:0]      addr,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic             done,
   output logic             cs_n,
   output logic             sck,
   output logic             mosi,
   input  logic             miso
);

   localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [7:0]     CMD_READ = 8'h03;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DATA, S_STALL, S_HOLD, S_FIN
   } state_e;

   state_e           state_q;
   logic [DIV_W-1:0] div_q;
   logic [4:0]       bit_q;
   logic [30:0]      tx_q;
   logic [7:0]       rx_q;
   logic [LEN_W-1:0] cnt_q;
   logic             busy_q, done_q, rd_valid_q, cs_n_q, sck_q, mosi_q;
   logic [7:0]       rd_data_q;

   logic div_last, slot_free, last_byte;

   assign div_last  = (div_q == DIV_LAST);
   assign slot_free = !rd_valid_q || rd_ready;
   assign last_byte = (cnt_q == LEN_W'(1));

   // tx_q holds the command/address bits still to go out after the one on mosi.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         cs_n_q     <= 1'b1;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (rd_valid_q && rd_ready) rd_valid_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               // A start coinciding with the done pulse is deliberately dropped.
               if (start && !done_q) begin
                  if (len != '0) begin
                     tx_q    <= {CMD_READ[6:0], addr};
                     mosi_q  <= CMD_READ[7];
                     cnt_q   <= len;
                     cs_n_q  <= 1'b0;
                     busy_q  <= 1'b1;
                     div_q   <= '0;
                     state_q <= S_SETUP;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end

            S_SETUP: begin
               if (div_last) begin
                  div_q   <= '0;
                  sck_q   <= 1'b1;
                  bit_q   <= '0;
                  state_q <= S_CMD;
               end else begin
                  div_q <= div_q + DIV_W'(1);
               end
            end

            S_CMD, S_ADDR, S_DATA: begin
               if (!div_last) begin
                  div_q <= div_q + DIV_W'(1);
               end else if (sck_q) begin
                  div_q  <= '0;
                  sck_q  <= 1'b0;
                  mosi_q <= tx_q[30];
                  tx_q   <= {tx_q[29:0], 1'b0};
               end else begin
                  div_q <= '0;
                  if (state_q == S_CMD) begin
                     sck_q <= 1'b1;
                     if (bit_q == 5'd7) begin
                        bit_q   <= '0;
                        state_q <= S_ADDR;
                     end else begin
                        bit_q <= bit_q + 5'd1;
                     end
                  end else if (state_q == S_ADDR) begin
                     sck_q <= 1'b1;
                     if (bit_q == 5'd23) begin
                        bit_q   <= '0;
                        rx_q    <= {rx_q[6:0], miso};
                        state_q <= S_DATA;
                     end else begin
                        bit_q <= bit_q + 5'd1;
                     end
                  end else if (bit_q != 5'd7) begin
                     sck_q <= 1'b1;
                     bit_q <= bit_q + 5'd1;
                     rx_q  <= {rx_q[6:0], miso};
                  end else if (slot_free) begin
                     rd_data_q  <= rx_q;
                     rd_valid_q <= 1'b1;
                     cnt_q      <= cnt_q - LEN_W'(1);
                     if (last_byte) begin
                        state_q <= S_HOLD;
                     end else begin
                        sck_q <= 1'b1;
                        bit_q <= '0;
                        rx_q  <= {rx_q[6:0], miso};
                     end
                  end else begin
                     state_q <= S_STALL;
                  end
               end
            end

            // Bus frozen with sck low until the consumer frees the output slot.
            S_STALL: begin
               if (rd_ready) begin
                  rd_data_q  <= rx_q;
                  rd_valid_q <= 1'b1;
                  cnt_q      <= cnt_q - LEN_W'(1);
                  div_q      <= '0;
                  if (last_byte) begin
                     state_q <= S_HOLD;
                  end else begin
                     sck_q   <= 1'b1;
                     bit_q   <= '0;
                     rx_q    <= {rx_q[6:0], miso};
                     state_q <= S_DATA;
                  end
               end
            end

            S_HOLD: begin
               if (div_last) begin
                  cs_n_q  <= 1'b1;
                  state_q <= S_FIN;
               end else begin
                  div_q <= div_q + DIV_W'(1);
               end
            end

            S_FIN: begin
               if (!rd_valid_q) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign cs_n     = cs_n_q;
   assign sck      = sck_q;
   assign mosi     = mosi_q;

endmodule
